obc_shift_accumulator: RTL and testbench
========================================

# obc_shift_accumulator

Bit-serial shift-accumulate stage of the OBC distributed-arithmetic DFT datapath. It consumes one signed OBC LUT word per input bit plane, MSB plane first, and combines them by Horner recursion with the MSB plane weighted negatively. It then adds the OBC offset term, halves the sum, and presents a 32-bit DFT partial term to the downstream add/shift combining stage through a valid/ready handshake.

## Interface
- NBITS, 16: bit planes per transform term (input sample width).
- LUT_W, 24: signed LUT word width.
- ACC_W, 32: accumulator/result width; must be ≥ LUT_W + 1.
- clk  input  1  rising-edge clock.
- rst  input  1  reset: one clock; reset is synchronous and active-high.
- start  input  1  begin a new term; sampled only in IDLE.
- offset  input  ACC_W  signed OBC offset constant; captured on accepted start.
- lut_valid  input  1  lut_data holds the next bit-plane word.
- lut_ready  output  1  block accepts a plane this cycle.
- lut_data  input  LUT_W  signed LUT word for the current plane.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts result.
- result  output  ACC_W  signed term = (acc + offset) >>> 1.
- overflow  output  1  sticky: some accumulation step wrapped, for the term currently in flight or presented.
- busy  output  1  state != IDLE.

## Operation
- States: IDLE, ACCUM, FINAL, DONE.
- IDLE:
  - start=1 → capture offset; clear the plane counter, acc and overflow; go to ACCUM.
- ACCUM:
  - lut_ready=1.
  - A beat is lut_valid & lut_ready; L = sign-extension of lut_data to ACC_W.
  - Beat 0 (MSB plane): acc ← −L.
  - Beats 1..NBITS-1: acc ← (acc << 1) + L.
  - The counter increments per beat; after beat NBITS-1, go to FINAL.
  - lut_valid=0 stalls: no state change.
- FINAL (one cycle):
  - acc ← acc + offset.
  - Go to DONE.
- DONE:
  - out_valid=1; result = acc >>> 1 (arithmetic), held stable.
  - out_valid & out_ready → IDLE.
- Arithmetic:
  - All operations are two's complement, wrapping mod 2^ACC_W.
  - overflow is set if any ACCUM or FINAL update's exact result falls outside the signed ACC_W range. It is cleared only by an accepted start or by rst.
- start is ignored when state != IDLE; it is neither queued nor allowed to corrupt the running term.
- lut_data is ignored outside ACCUM.
- offset changes after capture have no effect.
- rst at any time: return to IDLE with acc=0, counter=0, overflow=0. Any partial term is discarded.
- Reset values: lut_ready=0, out_valid=0, result=0, overflow=0, busy=0.

## Timing
- Cycle numbering:
  - start accepted at edge 0.
  - ACCUM covers edges 1..NBITS with lut_valid held high.
  - FINAL is edge NBITS+1.
  - out_valid is high after edge NBITS+1 and is seen first in cycle NBITS+2.
- Minimum latency from start to out_valid is NBITS+2 cycles; each stall cycle adds one.
- Back-to-back throughput is NBITS+3 cycles per term: the DONE handshake and the IDLE start cycle are each one cycle.
- lut_ready is combinational from state only, never from lut_valid.
- out_valid and result are registered.
- result is stable while out_valid=1 and out_ready=0.

## Test plan
- All-ones planes: NBITS beats of lut_data=1, offset=0.
  - Required: acc=−32768+32767=−1, result=0xFFFFFFFF, overflow=0.
  - Required: out_valid first seen 18 cycles after start.
- Single-plane term: beats 0..14 = 0, beat 15 = 10, offset=4.
  - Required: result=7 (0x00000007).
- Gapped input: same stimulus as the single-plane term with lut_valid deasserted on random cycles.
  - Required: identical result=7; latency grows by exactly the number of gap cycles.
- Backpressure and ignored start: out_ready low for 5 cycles in DONE, start pulsed during ACCUM and during DONE.
  - Required: result constant, no new term started, IDLE reached one cycle after out_ready=1.
- Overflow: beat 0 = 0, beats 1..15 = 0x7FFFFF, offset=0.
  - Required: overflow=1 at out_valid.
  - Required: the next term with all-zero planes reports overflow=0 and result=0.
- Reset mid-term: assert rst after 7 beats.
  - Required: next cycle busy=0, lut_ready=0, out_valid=0.
  - Required: a following all-ones term yields 0xFFFFFFFF.

Source files
------------

// File: rtl/obc_shift_accumulator.sv
// obc_shift_accumulator
// Bit-serial shift-accumulate stage of the OBC distributed-arithmetic DFT.
// Takes one signed LUT word per bit plane, MSB plane first. The MSB plane
// is negated, and each later plane is folded in by Horner recursion. The
// OBC offset is then added, the sum is halved, and the term is handed
// downstream through a valid/ready handshake.
module obc_shift_accumulator #(
   parameter int NBITS = 16,
   parameter int LUT_W = 24,
   parameter int ACC_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [ACC_W-1:0] offset,
   input  logic             lut_valid,
   output logic             lut_ready,
   input  logic [LUT_W-1:0] lut_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] result,
   output logic             overflow,
   output logic             busy
);

   // Two guard bits are enough for the exact value of 2*acc + L or acc + offset.
   localparam int XW = ACC_W + 2;
   localparam int CW = $clog2(NBITS + 1);

   typedef enum logic [1:0] {IDLE, ACCUM, FINAL, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] off_q, off_d;
   logic             ovf_q, ovf_d;
   logic             out_valid_q, out_valid_d;
   logic [ACC_W-1:0] result_q, result_d;

   logic [XW-1:0] acc_x, lut_x, off_x, sum_x;
   logic          sum_fits;

   // Next-state and datapath: Horner accumulation with exact-range overflow detection
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      off_d       = off_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;

      acc_x = {{2{acc_q[ACC_W-1]}}, acc_q};
      off_x = {{2{off_q[ACC_W-1]}}, off_q};
      lut_x = {{(XW-LUT_W){lut_data[LUT_W-1]}}, lut_data};
      sum_x = '0;

      case (state_q)
         IDLE: begin
            if (start) begin
               off_d   = offset;
               cnt_d   = '0;
               acc_d   = '0;
               ovf_d   = 1'b0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (lut_valid) begin
               if (cnt_q == '0) sum_x = '0 - lut_x;
               else             sum_x = (acc_x <<< 1) + lut_x;
               acc_d = sum_x[ACC_W-1:0];
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(NBITS - 1)) state_d = FINAL;
            end
         end
         FINAL: begin
            sum_x       = acc_x + off_x;
            acc_d       = sum_x[ACC_W-1:0];
            result_d    = {sum_x[ACC_W-1], sum_x[ACC_W-1:1]};
            out_valid_d = 1'b1;
            state_d     = DONE;
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // sum_x is only nonzero on an accumulation step, so this check is a no-op elsewhere
      sum_fits = (&sum_x[XW-1:ACC_W-1]) | ~(|sum_x[XW-1:ACC_W-1]);
      if (!sum_fits) ovf_d = 1'b1;
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         off_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         off_q       <= off_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
      end
   end

   // Outputs: handshake flags decoded from the state register only
   always_comb begin
      lut_ready = (state_q == ACCUM);
      busy      = (state_q != IDLE);
      out_valid = out_valid_q;
      result    = result_q;
      overflow  = ovf_q;
   end

endmodule

// File: tb/tb_obc_shift_accumulator.sv
// Directed testbench for obc_shift_accumulator (NBITS=16, LUT_W=24, ACC_W=32).
module tb_obc_shift_accumulator;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] offset;
   logic        lut_valid;
   logic        lut_ready;
   logic [23:0] lut_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        overflow;
   logic        busy;

   int n_checks;
   int n_fail;

   logic [23:0] planes [16];

   obc_shift_accumulator #(
      .NBITS(16),
      .LUT_W(24),
      .ACC_W(32)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .offset   (offset),
      .lut_valid(lut_valid),
      .lut_ready(lut_ready),
      .lut_data (lut_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result),
      .overflow (overflow),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Drives one complete term and waits (bounded) for out_valid.
   // lat counts clock edges from the start edge up to first sight of out_valid.
   task automatic run_term(input logic [31:0] off, input logic [15:0] gap_mask,
                           input int start_beat, output int lat, output bit tmo);
      int k;
      start  = 1'b1;
      offset = off;
      step;
      start  = 1'b0;
      offset = 32'hDEAD_BEEF;
      lat    = 1;
      for (int i = 0; i < 16; i++) begin
         if (gap_mask[i]) begin
            lut_valid = 1'b0;
            lut_data  = 24'hABCDEF;
            step;
            lat++;
         end
         lut_valid = 1'b1;
         lut_data  = planes[i];
         start     = (i == start_beat);
         step;
         lat++;
         start = 1'b0;
      end
      lut_valid = 1'b0;
      lut_data  = 24'h555555;
      k = 0;
      while (!out_valid && k < 60) begin
         step;
         lat++;
         k++;
      end
      tmo = !out_valid;
   endtask

   task automatic accept;
      out_ready = 1'b1;
      step;
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      step;
      step;
      n_checks++; if (lut_ready !== 1'b0) begin n_fail++; $display("FAIL reset_lut_ready: got %b expected 0", lut_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 00000000", result); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      rst = 1'b0;
      step;
   endtask

   task automatic test_all_ones;
      int lat;
      bit tmo;
      for (int i = 0; i < 16; i++) planes[i] = 24'd1;
      run_term(32'd0, 16'h0000, -1, lat, tmo);
      n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL ones_timeout: got out_valid=%b expected 1", out_valid); end
      n_checks++; if (lat !== 18) begin n_fail++; $display("FAIL ones_latency: got %0d expected 18", lat); end
      n_checks++; if (result !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL ones_result: got %h expected ffffffff", result); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ones_overflow: got %b expected 0", overflow); end
      accept;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ones_idle: got busy=%b expected 0", busy); end
   endtask

   task automatic test_single_plane;
      int lat;
      bit tmo;
      for (int i = 0; i < 16; i++) planes[i] = 24'd0;
      planes[15] = 24'd10;
      run_term(32'd4, 16'h0000, -1, lat, tmo);
      n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL single_timeout: got out_valid=%b expected 1", out_valid); end
      n_checks++; if (result !== 32'h00000007) begin n_fail++; $display("FAIL single_result: got %h expected 00000007", result); end
      n_checks++; if (lat !== 18) begin n_fail++; $display("FAIL single_latency: got %0d expected 18", lat); end
      accept;
   endtask

   task automatic test_gapped;
      int lat;
      bit tmo;
      logic [15:0] mask;
      int exp_lat;
      for (int i = 0; i < 16; i++) planes[i] = 24'd0;
      planes[15] = 24'd10;
      mask = 16'($urandom_range(16'hFFFF, 1));
      exp_lat = 18 + $countones(mask);
      run_term(32'd4, mask, -1, lat, tmo);
      n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL gapped_timeout: got out_valid=%b expected 1", out_valid); end
      n_checks++; if (result !== 32'h00000007) begin n_fail++; $display("FAIL gapped_result: got %h expected 00000007", result); end
      n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL gapped_latency: got %0d expected %0d (mask %h)", lat, exp_lat, mask); end
      accept;
   endtask

   task automatic test_backpressure;
      int lat;
      bit tmo;
      for (int i = 0; i < 16; i++) planes[i] = 24'd0;
      planes[15] = 24'd10;
      run_term(32'd4, 16'h0000, 5, lat, tmo);
      n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL bp_timeout: got out_valid=%b expected 1", out_valid); end
      n_checks++; if (result !== 32'h00000007) begin n_fail++; $display("FAIL bp_result: got %h expected 00000007", result); end
      for (int c = 0; c < 5; c++) begin
         out_ready = 1'b0;
         start     = (c == 2);
         step;
         start = 1'b0;
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", c, out_valid); end
         n_checks++; if (result !== 32'h00000007) begin n_fail++; $display("FAIL bp_hold_result[%0d]: got %h expected 00000007", c, result); end
      end
      accept;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle_busy: got %b expected 0", busy); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle_valid: got %b expected 0", out_valid); end
      step;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_no_queued_start: got busy=%b expected 0", busy); end
   endtask

   task automatic test_overflow;
      int lat;
      bit tmo;
      planes[0] = 24'd0;
      for (int i = 1; i < 16; i++) planes[i] = 24'h7FFFFF;
      run_term(32'd0, 16'h0000, -1, lat, tmo);
      n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL ovf_timeout: got out_valid=%b expected 1", out_valid); end
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
      // (2^23-1)(2^15-1) mod 2^32 = 0xFF7F8001, halved arithmetically
      n_checks++; if (result !== 32'hFFBFC000) begin n_fail++; $display("FAIL ovf_result: got %h expected ffbfc000", result); end
      accept;
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky_idle: got %b expected 1", overflow); end
      for (int i = 0; i < 16; i++) planes[i] = 24'd0;
      run_term(32'd0, 16'h0000, -1, lat, tmo);
      n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL zero_timeout: got out_valid=%b expected 1", out_valid); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL zero_overflow: got %b expected 0", overflow); end
      n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL zero_result: got %h expected 00000000", result); end
      accept;
   endtask

   task automatic test_reset_mid;
      int lat;
      bit tmo;
      for (int i = 0; i < 16; i++) planes[i] = 24'd1;
      start  = 1'b1;
      offset = 32'd0;
      step;
      start     = 1'b0;
      lut_valid = 1'b0;
      n_checks++; if (lut_ready !== 1'b1) begin n_fail++; $display("FAIL mid_lut_ready_stall: got %b expected 1", lut_ready); end
      for (int i = 0; i < 7; i++) begin
         lut_valid = 1'b1;
         lut_data  = 24'hFFFFFF;
         step;
      end
      lut_valid = 1'b0;
      rst = 1'b1;
      step;
      rst = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
      n_checks++; if (lut_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_lut_ready: got %b expected 0", lut_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out_valid: got %b expected 0", out_valid); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_rst_overflow: got %b expected 0", overflow); end
      run_term(32'd0, 16'h0000, -1, lat, tmo);
      n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL mid_after_timeout: got out_valid=%b expected 1", out_valid); end
      n_checks++; if (result !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mid_after_result: got %h expected ffffffff", result); end
      n_checks++; if (lat !== 18) begin n_fail++; $display("FAIL mid_after_latency: got %0d expected 18", lat); end
      accept;
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst       = 1'b1;
      start     = 1'b0;
      offset    = '0;
      lut_valid = 1'b0;
      lut_data  = '0;
      out_ready = 1'b0;
      test_reset;
      test_all_ones;
      test_single_plane;
      test_gapped;
      test_backpressure;
      test_overflow;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
